fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the fetch address loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port stall, input, 1, hold request from downstream hazard logic.
REQ-005 SHALL have port redirect, input, 1, taken branch from a later stage.
REQ-006 SHALL have port redirect_target, input, 32, byte address of the taken branch.
REQ-007 SHALL have port imem_addr, output, 32, byte address driven to the combinational instruction memory.
REQ-008 SHALL have port imem_instr, input, 32, instruction returned combinationally for imem_addr.
REQ-009 SHALL have port if_id_instr, output, 32, registered fetched instruction.
REQ-010 SHALL have port if_id_pc_plus4, output, 32, registered fetch address + 4 of if_id_instr.
REQ-011 SHALL have port if_id_valid, output, 1, if_id_instr holds a real instruction.
REQ-012 SHALL have port fetch_count, output, 16, count of instructions delivered into IF/ID.

Function
REQ-013 SHALL hold a 32-bit PC register; imem_addr SHALL equal PC combinationally, with no added cycle.
REQ-014 SHALL compute pc_plus4 = PC + 4 modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-015 SHALL decode imem_instr[31:26] == 6'b000010 as jump; jump target = {pc_plus4[31:28], imem_instr[25:0], 2'b00}.
REQ-016 SHALL select next PC by priority: reset > redirect > stall > jump > sequential.
REQ-017 redirect SHALL load PC with {redirect_target[31:2], 2'b00}; misaligned low bits SHALL be dropped.
REQ-018 redirect SHALL clear if_id_valid on the same edge; if_id_instr and if_id_pc_plus4 are don't-care.
REQ-019 stall without redirect SHALL hold PC, if_id_instr, if_id_pc_plus4, if_id_valid and fetch_count unchanged.
REQ-020 redirect asserted together with stall SHALL win: PC redirected, if_id_valid cleared.
REQ-021 jump without redirect or stall SHALL load PC with the jump target; the jump instruction itself SHALL enter IF/ID with valid=1.
REQ-022 No delay slot SHALL be fetched after a jump; the jump costs zero bubble cycles.
REQ-023 sequential case SHALL load PC with pc_plus4, if_id_instr with imem_instr, if_id_pc_plus4 with pc_plus4, if_id_valid with 1.
REQ-024 fetch_count SHALL increment by 1 on each edge that writes if_id_valid=1; it SHALL wrap 16'hFFFF -> 16'h0000.
REQ-025 Fetch latency SHALL be 1 cycle: instruction at PC appears on if_id_instr after the next rising edge.

Reset
REQ-026 On reset, PC SHALL load RESET_PC, if_id_instr 32'h0, if_id_pc_plus4 32'h0, if_id_valid 0, fetch_count 0.
REQ-027 reset SHALL override stall, redirect and jump on the same edge.
REQ-028 reset asserted mid-stream SHALL discard the in-flight IF/ID contents.
REQ-029 First valid instruction SHALL appear in IF/ID on the first edge after reset deasserts.

Verification
REQ-030 Reset for 2 cycles, release -> imem_addr 0x0, then 0x4, 0x8; if_id_valid rises one cycle after release; fetch_count 1, 2, 3.
REQ-031 PC 0x28 with imem_instr 32'h0800_0002 -> if_id_instr 32'h0800_0002, if_id_pc_plus4 0x2C, next imem_addr 0x8.
REQ-032 stall high 3 cycles at PC 0x10 -> imem_addr stays 0x10; IF/ID and fetch_count unchanged; resumes to 0x14 on release.
REQ-033 redirect=1, redirect_target 0x21 -> next imem_addr 0x20, if_id_valid 0, fetch_count unchanged.
REQ-034 redirect and stall both high, target 0x40 -> imem_addr 0x40, if_id_valid 0 next cycle.
REQ-035 PC forced to 0xFFFF_FFFC with a non-jump instruction -> if_id_pc_plus4 0x0, next imem_addr 0x0; fetch_count preset to 0xFFFF wraps to 0x0000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC selection and IF/ID register.
// Redirects beat stalls, stalls beat jumps; jumps resolve here with no bubble.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [15:0] fetch_count
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] next_pc;
  logic        is_jump;
  logic        sel_redir;
  logic        sel_stall;
  logic        sel_jump;
  logic        sel_seq;
  logic        fetch_en;

  assign imem_addr   = pc;
  assign pc_plus4    = pc + 32'd4;
  assign is_jump     = (imem_instr[31:26] == 6'b000010);
  assign jump_target = {pc_plus4[31:28], imem_instr[25:0], 2'b00};

  // One-hot select so the priority order is explicit and exclusive.
  assign sel_redir = redirect;
  assign sel_stall = stall & ~redirect;
  assign sel_jump  = is_jump & ~stall & ~redirect;
  assign sel_seq   = ~is_jump & ~stall & ~redirect;
  assign fetch_en  = sel_jump | sel_seq;

  // Next-PC mux.
  always_comb begin
    next_pc = pc_plus4;
    unique case (1'b1)
      sel_redir: next_pc = {redirect_target[31:2], 2'b00};
      sel_stall: next_pc = pc;
      sel_jump:  next_pc = jump_target;
      sel_seq:   next_pc = pc_plus4;
      default:   next_pc = pc_plus4;
    endcase
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= next_pc;
    end
  end

  // IF/ID register and delivered-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_instr    <= 32'h0;
      if_id_pc_plus4 <= 32'h0;
      if_id_valid    <= 1'b0;
      fetch_count    <= 16'h0;
    end else if (sel_redir) begin
      if_id_valid <= 1'b0;
    end else if (fetch_en) begin
      if_id_instr    <= imem_instr;
      if_id_pc_plus4 <= pc_plus4;
      if_id_valid    <= 1'b1;
      fetch_count    <= fetch_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus reset and
// counter-wrap sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic [15:0] fetch_count;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .if_id_instr     (if_id_instr),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .if_id_valid     (if_id_valid),
    .fetch_count     (fetch_count)
  );

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] target;
    logic [31:0] instr;
    logic [31:0] e_addr;
    logic        e_valid;
    logic        chk_data;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    logic st, logic rd, logic [31:0] tg, logic [31:0] ins,
    logic [31:0] ea, logic ev, logic cd, logic [31:0] ei,
    logic [31:0] ep, logic [15:0] ec);
    vec_t v;
    v.stall = st; v.redir = rd; v.target = tg; v.instr = ins;
    v.e_addr = ea; v.e_valid = ev; v.chk_data = cd;
    v.e_instr = ei; v.e_pc4 = ep; v.e_cnt = ec;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(logic st, logic rd, logic [31:0] tg,
                      logic [31:0] ins);
    stall = st;
    redirect = rd;
    redirect_target = tg;
    imem_instr = ins;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(string tag, logic [31:0] ea, logic ev,
                           logic cd, logic [31:0] ei,
                           logic [31:0] ep, logic [15:0] ec);
    check({tag, ".addr"}, imem_addr, ea);
    check({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, ev});
    check({tag, ".count"}, {16'h0, fetch_count}, {16'h0, ec});
    if (cd) begin
      check({tag, ".instr"}, if_id_instr, ei);
      check({tag, ".pc4"}, if_id_pc_plus4, ep);
    end
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_target = 32'h0;
    imem_instr = NOP;

    // Table: each row drives one cycle and checks just after the edge.
    // Starts at PC 0 right after reset release.
    vt.push_back(mk(0,0,0,NOP,        32'h4, 1,1,NOP,        32'h4, 1));
    vt.push_back(mk(0,0,0,32'h1111_0001,32'h8, 1,1,32'h1111_0001,32'h8, 2));
    vt.push_back(mk(0,0,0,32'h2222_0002,32'hC, 1,1,32'h2222_0002,32'hC, 3));
    vt.push_back(mk(0,0,0,32'h3333_0003,32'h10,1,1,32'h3333_0003,32'h10,4));
    // stall three cycles at PC 0x10
    vt.push_back(mk(1,0,0,32'h4444_0004,32'h10,1,1,32'h3333_0003,32'h10,4));
    vt.push_back(mk(1,0,0,32'h4444_0004,32'h10,1,1,32'h3333_0003,32'h10,4));
    vt.push_back(mk(1,0,0,32'h4444_0004,32'h10,1,1,32'h3333_0003,32'h10,4));
    vt.push_back(mk(0,0,0,32'h4444_0004,32'h14,1,1,32'h4444_0004,32'h14,5));
    // misaligned redirect to 0x2A lands at 0x28
    vt.push_back(mk(0,1,32'h2A,32'h5555_0005,32'h28,0,0,0,0,5));
    // jump at 0x28 to 0x8
    vt.push_back(mk(0,0,0,32'h0800_0002,32'h8,1,1,32'h0800_0002,32'h2C,6));
    // redirect to 0x21 -> 0x20
    vt.push_back(mk(0,1,32'h21,NOP,32'h20,0,0,0,0,6));
    // redirect together with stall
    vt.push_back(mk(1,1,32'h40,NOP,32'h40,0,0,0,0,6));
    // stall alone keeps the bubble
    vt.push_back(mk(1,0,0,32'h0800_0003,32'h40,0,0,0,0,6));
    // jump with max index field
    vt.push_back(mk(0,0,0,32'h0BFF_FFFF,32'h0FFF_FFFC,1,1,
                    32'h0BFF_FFFF,32'h44,7));
    vt.push_back(mk(0,0,0,NOP,32'h1000_0000,1,1,NOP,32'h1000_0000,8));
    // jump keeps pc_plus4 upper nibble
    vt.push_back(mk(0,0,0,32'h0800_0010,32'h1000_0040,1,1,
                    32'h0800_0010,32'h1000_0004,9));
    vt.push_back(mk(0,0,32'h0,32'h0800_0001,32'h1000_0004,1,1,
                    32'h0800_0001,32'h1000_0044,10));
    // wrap of the PC at the top of the address space
    vt.push_back(mk(0,1,32'hFFFF_FFFC,NOP,32'hFFFF_FFFC,0,0,0,0,10));
    vt.push_back(mk(0,0,0,32'h6666_0006,32'h0,1,1,32'h6666_0006,32'h0,11));

    // reset held two cycles
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_all("reset", 32'h0, 1'b0, 1'b1, 32'h0, 32'h0, 16'h0);

    reset = 1'b0;
    foreach (vt[i]) begin
      step(vt[i].stall, vt[i].redir, vt[i].target, vt[i].instr);
      check_all($sformatf("vec%0d", i), vt[i].e_addr, vt[i].e_valid,
                vt[i].chk_data, vt[i].e_instr, vt[i].e_pc4, vt[i].e_cnt);
    end

    // reset mid-stream beats redirect, stall and jump
    reset = 1'b1;
    step(1, 1, 32'h80, 32'h0800_0005);
    check_all("midreset", 32'h0, 1'b0, 1'b1, 32'h0, 32'h0, 16'h0);
    reset = 1'b0;
    step(0, 0, 0, 32'h7777_0007);
    check_all("first", 32'h4, 1'b1, 1'b1, 32'h7777_0007, 32'h4, 16'h1);

    // drive the counter to 0xFFFF, then through the PC wrap
    for (int k = 1; k < 65535; k++) step(0, 0, 0, NOP);
    check_all("cnt_max", 32'h0003_FFFC, 1'b1, 1'b1, NOP,
              32'h0003_FFFC, 16'hFFFF);
    step(0, 1, 32'hFFFF_FFFC, NOP);
    check_all("redir_top", 32'hFFFF_FFFC, 1'b0, 1'b0, 0, 0, 16'hFFFF);
    step(0, 0, 0, 32'h1234_5678);
    check_all("cnt_wrap", 32'h0, 1'b1, 1'b1, 32'h1234_5678,
              32'h0, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
